// File: rtl/fp32_div_seq.sv
// ---------------------------------------------------------------------------
// fp32_div_seq
//
// Sequential IEEE-754 binary32 divider computing X / Y. The mantissa quotient
// comes from a restoring divider that produces one quotient bit per clock.
// Special values and flags follow the same conventions as the team's
// combinational fp32 multiplier. Denormal inputs are flushed to zero, and the
// quotient is truncated (no rounding).
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   start      in   1   request a division, only sampled while idle
//   X          in  32   dividend, latched on the edge that accepts start
//   Y          in  32   divisor, latched on the same edge
//   busy       out  1   an operation is in flight (state != IDLE)
//   done       out  1   one-cycle pulse, result and flags are valid
//   result     out 32   quotient, held until the next operation's setup edge
//   inf        out  1   result is a signed infinity (special case)
//   nan        out  1   result is the canonical quiet NaN
//   zero       out  1   result is a signed zero (special case)
//   overflow   out  1   exponent too large, saturated to signed infinity
//   underflow  out  1   exponent too small, flushed to signed zero
// ---------------------------------------------------------------------------
module fp32_div_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        inf,
    output logic        nan,
    output logic        zero,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_DIVIDE,
        S_PACK,
        S_DONE
    } state_t;

    state_t             state_q;

    // Latched operands
    logic [31:0]        x_q;
    logic [31:0]        y_q;

    // Divider datapath
    logic [24:0]        rem_q;
    logic [23:0]        my_q;
    logic [22:0]        q_q;
    logic [4:0]         cnt_q;
    logic signed [9:0]  exp_q;
    logic               sign_q;

    // Registered outputs
    logic               busy_q;
    logic               done_q;
    logic [31:0]        result_q;
    logic               inf_q;
    logic               nan_q;
    logic               zero_q;
    logic               overflow_q;
    logic               underflow_q;

    // Operand classification and setup values, derived from latched operands
    logic [7:0]         exp_x;
    logic [7:0]         exp_y;
    logic [22:0]        frac_x;
    logic [22:0]        frac_y;
    logic               x_is_zero;
    logic               y_is_zero;
    logic               x_is_inf;
    logic               y_is_inf;
    logic               x_is_nan;
    logic               y_is_nan;
    logic               sign_d;
    logic [23:0]        mant_x_d;
    logic [23:0]        mant_y_d;
    logic               adj_d;
    logic [24:0]        rem_init_d;
    logic signed [9:0]  exp_d;

    logic               special_hit_d;
    logic [31:0]        special_result_d;
    logic               special_inf_d;
    logic               special_nan_d;
    logic               special_zero_d;

    // Restoring step
    logic               rem_ge_d;
    logic [24:0]        rem_sub_d;
    logic [24:0]        rem_next_d;

    // Classify the latched operands. Denormals are flushed to zero by forcing
    // their fraction to zero, so they classify as zero everywhere below.
    always_comb begin
        exp_x     = x_q[30:23];
        exp_y     = y_q[30:23];
        frac_x    = (exp_x == 8'h00) ? 23'd0 : x_q[22:0];
        frac_y    = (exp_y == 8'h00) ? 23'd0 : y_q[22:0];

        x_is_zero = (exp_x == 8'h00);
        y_is_zero = (exp_y == 8'h00);
        x_is_inf  = (exp_x == 8'hFF) && (frac_x == 23'd0);
        y_is_inf  = (exp_y == 8'hFF) && (frac_y == 23'd0);
        x_is_nan  = (exp_x == 8'hFF) && (frac_x != 23'd0);
        y_is_nan  = (exp_y == 8'hFF) && (frac_y != 23'd0);

        sign_d    = x_q[31] ^ y_q[31];
        mant_x_d  = {1'b1, frac_x};
        mant_y_d  = {1'b1, frac_y};

        // Pre-normalising the dividend guarantees the first quotient bit is 1,
        // so the quotient never needs a post-shift.
        adj_d      = (mant_x_d < mant_y_d);
        rem_init_d = adj_d ? {mant_x_d, 1'b0} : {1'b0, mant_x_d};

        // Unsigned 10-bit arithmetic wraps to the correct two's-complement
        // value; the result spans -127..380 for normal operands.
        exp_d = $signed({2'b00, exp_x} - {2'b00, exp_y} + 10'd127 - {9'd0, adj_d});
    end

    // Special-case detection in priority order: NaN-producing cases first,
    // then division by zero, then infinite dividend, then zero quotients.
    always_comb begin
        special_hit_d    = 1'b0;
        special_result_d = 32'h0000_0000;
        special_inf_d    = 1'b0;
        special_nan_d    = 1'b0;
        special_zero_d   = 1'b0;

        if (x_is_nan || y_is_nan || (x_is_zero && y_is_zero) || (x_is_inf && y_is_inf)) begin
            special_hit_d    = 1'b1;
            special_result_d = 32'h7FC0_0000;
            special_nan_d    = 1'b1;
        end else if (y_is_zero) begin
            special_hit_d    = 1'b1;
            special_result_d = {sign_d, 8'hFF, 23'd0};
            special_inf_d    = 1'b1;
        end else if (x_is_inf) begin
            special_hit_d    = 1'b1;
            special_result_d = {sign_d, 8'hFF, 23'd0};
            special_inf_d    = 1'b1;
        end else if (x_is_zero || y_is_inf) begin
            special_hit_d    = 1'b1;
            special_result_d = {sign_d, 31'd0};
            special_zero_d   = 1'b1;
        end
    end

    // One restoring iteration. After a subtraction the remainder is below
    // the divisor (< 2^24), so the left shift never loses a set bit.
    always_comb begin
        rem_ge_d   = (rem_q >= {1'b0, my_q});
        rem_sub_d  = rem_ge_d ? (rem_q - {1'b0, my_q}) : rem_q;
        rem_next_d = rem_sub_d << 1;
    end

    // Control FSM with registered outputs. The quotient register keeps only
    // the 23 fraction bits: the leading 1 shifts out of the top, which is
    // harmless because it is always 1 and becomes the hidden bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            x_q         <= 32'd0;
            y_q         <= 32'd0;
            rem_q       <= 25'd0;
            my_q        <= 24'd0;
            q_q         <= 23'd0;
            cnt_q       <= 5'd0;
            exp_q       <= 10'sd0;
            sign_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 32'd0;
            inf_q       <= 1'b0;
            nan_q       <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q     <= X;
                        y_q     <= Y;
                        busy_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    inf_q       <= 1'b0;
                    nan_q       <= 1'b0;
                    zero_q      <= 1'b0;
                    overflow_q  <= 1'b0;
                    underflow_q <= 1'b0;
                    if (special_hit_d) begin
                        result_q <= special_result_d;
                        inf_q    <= special_inf_d;
                        nan_q    <= special_nan_d;
                        zero_q   <= special_zero_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        my_q    <= mant_y_d;
                        rem_q   <= rem_init_d;
                        exp_q   <= exp_d;
                        sign_q  <= sign_d;
                        q_q     <= 23'd0;
                        cnt_q   <= 5'd0;
                        state_q <= S_DIVIDE;
                    end
                end

                S_DIVIDE: begin
                    rem_q <= rem_next_d;
                    q_q   <= {q_q[21:0], rem_ge_d};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd23) begin
                        state_q <= S_PACK;
                    end
                end

                S_PACK: begin
                    if (exp_q <= 10'sd0) begin
                        result_q    <= {sign_q, 31'd0};
                        underflow_q <= 1'b1;
                    end else if (exp_q >= 10'sd255) begin
                        result_q   <= {sign_q, 8'hFF, 23'd0};
                        overflow_q <= 1'b1;
                    end else begin
                        result_q <= {sign_q, exp_q[7:0], q_q};
                    end
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign inf       = inf_q;
    assign nan       = nan_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fp32_div_seq.sv
// ---------------------------------------------------------------------------
// tb_fp32_div_seq
//
// Self-checking bench for fp32_div_seq. Directed cases cover the documented
// examples, specials, range limits, handshake and reset behaviour; a random
// phase compares against an arithmetic reference model of X / Y.
// ---------------------------------------------------------------------------
module tb_fp32_div_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] X;
    logic [31:0] Y;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        inf;
    logic        nan;
    logic        zero;
    logic        overflow;
    logic        underflow;

    int checkCount;
    int errorCount;

    fp32_div_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .X         (X),
        .Y         (Y),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .inf       (inf),
        .nan       (nan),
        .zero      (zero),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and log mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Result and flags packed as {result, inf, nan, zero, overflow, underflow}
    function automatic logic [63:0] outVec();
        return {27'd0, result, inf, nan, zero, overflow, underflow};
    endfunction

    // Reference model built from the IEEE rules with integer arithmetic
    task automatic refDiv(input logic [31:0] x, input logic [31:0] y,
                          output logic [63:0] expVec, output int expLat);
        int          ex, ey, e;
        longint      mx, my, q;
        logic        s, zx, zy, ix, iy, nx, ny;
        logic [31:0] r;
        logic [4:0]  flags;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = (ex == 0) ? 0 : longint'(x[22:0]);
        my = (ey == 0) ? 0 : longint'(y[22:0]);
        s  = x[31] ^ y[31];
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (mx == 0);
        iy = (ey == 255) && (my == 0);
        nx = (ex == 255) && (mx != 0);
        ny = (ey == 255) && (my != 0);
        expLat = 1;
        if (nx || ny || (zx && zy) || (ix && iy)) begin
            r = 32'h7FC0_0000;      flags = 5'b01000;
        end else if (zy || ix) begin
            r = {s, 8'hFF, 23'd0};  flags = 5'b10000;
        end else if (zx || iy) begin
            r = {s, 31'd0};         flags = 5'b00100;
        end else begin
            expLat = 26;
            mx = mx + 64'd8388608;
            my = my + 64'd8388608;
            e  = ex - ey + 127;
            if (mx < my) begin
                e = e - 1;
                q = (mx * 64'd16777216) / my;
            end else begin
                q = (mx * 64'd8388608) / my;
            end
            if (e <= 0) begin
                r = {s, 31'd0};         flags = 5'b00001;
            end else if (e >= 255) begin
                r = {s, 8'hFF, 23'd0};  flags = 5'b00010;
            end else begin
                r = {s, 8'(e), 23'(q)}; flags = 5'b00000;
            end
        end
        expVec = {27'd0, r, flags};
    endtask

    // Issue one division and wait (bounded) for done. glitchEdge, if >= 0,
    // raises start with fresh operands for one cycle at that edge count.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                 input int glitchEdge, output int lat,
                                 output logic busyOk);
        @(negedge clk);
        X     = x;
        Y     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        X      = $urandom;
        Y      = $urandom;
        lat    = 0;
        busyOk = busy;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (!busy) busyOk = 1'b0;
            if (lat == glitchEdge) begin
                start = 1'b1;
                X     = $urandom;
                Y     = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    // Run one operation and check latency, outputs, busy and the done drop
    task automatic runAndCheck(input string tag, input logic [31:0] x,
                               input logic [31:0] y, input logic [63:0] expVec,
                               input int expLat, input int glitchEdge);
        int   lat;
        logic busyOk;
        applyStimulus(x, y, glitchEdge, lat, busyOk);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(expLat));
        checkOutput({tag, "_out"}, outVec(), expVec);
        checkOutput({tag, "_busy"}, {63'd0, busyOk}, 64'd1);
        @(posedge clk);
        #1;
        checkOutput({tag, "_after"}, {62'd0, busy, done}, 64'd0);
        checkOutput({tag, "_hold"}, outVec(), expVec);
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic [4:0]  flags;
        int          lat;
    } dirCase_t;

    dirCase_t dirCases[10];

    initial begin
        logic [63:0] expVec;
        int          expLat;
        int          n;
        logic        sawDone;
        logic [31:0] rx, ry;

        checkCount = 0;
        errorCount = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        X          = 32'd0;
        Y          = 32'd0;

        dirCases[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 26};
        dirCases[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 5'b00000, 26};
        dirCases[2] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 5'b10000, 1};
        dirCases[3] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b01000, 1};
        dirCases[4] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b01000, 1};
        dirCases[5] = '{32'h40000000, 32'h7F800000, 32'h00000000, 5'b00100, 1};
        dirCases[6] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b01000, 1};
        dirCases[7] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 5'b00010, 26};
        dirCases[8] = '{32'h00800000, 32'h7F000000, 32'h00000000, 5'b00001, 26};
        dirCases[9] = '{32'h00400000, 32'h3F800000, 32'h00000000, 5'b00100, 1};

        #12;
        checkOutput("reset_state", {25'd0, busy, done, result, inf, nan, zero,
                    overflow, underflow}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            runAndCheck($sformatf("dir%0d", i), dirCases[i].x, dirCases[i].y,
                        {27'd0, dirCases[i].r, dirCases[i].flags},
                        dirCases[i].lat, -1);
        end

        // start during DIVIDE count 10 is ignored
        runAndCheck("glitch", 32'h40C00000, 32'h40000000,
                    {27'd0, 32'h40400000, 5'b00000}, 26, 11);

        // start held high: back-to-back operations with one idle cycle between
        @(negedge clk);
        X     = 32'h3F800000;
        Y     = 32'h40400000;
        start = 1'b1;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("held_first_lat", 64'(n), 64'd27);
        checkOutput("held_first_out", outVec(), {27'd0, 32'h3EAAAAAA, 5'b00000});
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!done && n < 100);
            checkOutput($sformatf("held_gap%0d", k), 64'(n), 64'd28);
            checkOutput($sformatf("held_out%0d", k), outVec(),
                        {27'd0, 32'h3EAAAAAA, 5'b00000});
        end
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);

        // Asynchronous reset in the middle of DIVIDE
        runAndCheck("pre_reset", 32'h40C00000, 32'h40000000,
                    {27'd0, 32'h40400000, 5'b00000}, 26, -1);
        @(negedge clk);
        X     = 32'h40C00000;
        Y     = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset", {25'd0, busy, done, result, inf, nan, zero,
                    overflow, underflow}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sawDone = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1'b1;
        end
        checkOutput("no_done_after_reset", {63'd0, sawDone}, 64'd0);
        runAndCheck("post_reset", 32'h3F800000, 32'h40400000,
                    {27'd0, 32'h3EAAAAAA, 5'b00000}, 26, -1);

        // Randomized operands against the reference model
        for (int i = 0; i < 150; i++) begin
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 3) != 0) rx[30:23] = 8'($urandom_range(1, 254));
            if ($urandom_range(0, 3) != 0) ry[30:23] = 8'($urandom_range(1, 254));
            case ($urandom_range(0, 9))
                0: rx[30:0] = 31'd0;
                1: ry[30:0] = 31'd0;
                2: rx[30:23] = 8'hFF;
                3: ry[30:23] = 8'hFF;
                4: begin rx[30:23] = 8'hFF; rx[22:0] = 23'd0; end
                5: begin ry[30:23] = 8'hFF; ry[22:0] = 23'd0; end
                6: ry[30:23] = 8'h00;
                default: ;
            endcase
            refDiv(rx, ry, expVec, expLat);
            runAndCheck($sformatf("rand%0d", i), rx, ry, expVec, expLat, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/fp32_div_seq.md
Name: fp32_div_seq

Overview:
- Sequential IEEE-754 binary32 divider (X / Y); the inverse operation of the team's combinational fp32 multiplier.
- It uses the same flag set and the same special-value conventions as that multiplier.
- The mantissa quotient comes from an iterative restoring divider, one quotient bit per clock.
- A start/done handshake with a busy indication lets the datapath controller issue one division at a time.

Parameters:
- None. The format is fixed at binary32: 8-bit exponent, bias 127, 23-bit fraction.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- X  input  32  dividend; sampled on the edge that accepts start.
- Y  input  32  divisor; sampled on the same edge.
- busy  output  1  high while an operation is in flight (state != IDLE).
- done  output  1  one-cycle pulse: result and flags are valid.
- result  output  32  quotient.
- inf  output  1  flag, per the classification rules below.
- nan  output  1  flag, per the classification rules below.
- zero  output  1  flag, per the classification rules below.
- overflow  output  1  flag, per the classification rules below.
- underflow  output  1  flag, per the classification rules below.

Behaviour:

Reset:
- reset_n low asynchronously forces state IDLE.
- busy, done, all flags = 0; result = 32'h0; internal registers cleared.
- A reset during SETUP, DIVIDE or PACK aborts the operation; no done pulse follows.

States:
- IDLE: if start=1, latch X and Y, go to SETUP. Otherwise stay.
- SETUP, one cycle, classifies operands:
  - Denormal inputs (exp=0, frac!=0) are flushed to zero first.
  - Signed sign s = X[31]^Y[31].
  - Special cases are checked in priority order; on a hit, result and flags are written on this edge and the state goes to DONE.
  - Otherwise: load Mx={1,fracX}, My={1,fracY}.
  - If Mx<My, shift Mx left 1 and set adj=1; else adj=0.
  - Compute signed 10-bit e = Ex - Ey + 127 - adj. Clear the counter, go to DIVIDE.
- DIVIDE, 24 cycles, count 0..23:
  - Restoring step on a 25-bit remainder R (initially Mx).
  - If R>=My then q bit=1 and R=R-My; else q bit=0.
  - Then R=R<<1. Quotient bits fill MSB first.
  - After count 23, go to PACK.
- PACK, one cycle, writes result and flags, then goes to DONE:
  - If e<=0: result={s,31'b0}, underflow=1.
  - If e>=255: result={s,8'hFF,23'b0}, overflow=1.
  - Else: result={s,e[7:0],q[22:0]}. Truncate; no rounding. q[23] is always 1.
- DONE: done=1 for exactly this cycle, then go to IDLE.

Output holding:
- result and flags hold until the SETUP edge of the next accepted operation.
- On that edge, all flags clear before being re-evaluated.

Special cases, priority order, sign s unless stated:
1. Either operand NaN, or 0/0, or inf/inf: result=32'h7FC00000, nan=1.
2. Finite nonzero / 0: result={s,8'hFF,23'b0}, inf=1.
3. inf / finite: result={s,8'hFF,23'b0}, inf=1.
4. 0 / nonzero finite or inf, or finite / inf: result={s,31'b0}, zero=1.

Flag exclusivity:
- At most one flag is 1.
- overflow and underflow are never set together with inf or zero.

Latency, counted from the edge that samples start:
- done is high after edge +26 for the normal path.
- done is high after edge +1 for special cases.
- busy is high from the sampling edge until the DONE cycle ends.

Handshake:
- start while busy (including the DONE cycle) is ignored; X and Y are not re-latched.
- start held high continuously re-triggers at IDLE, one cycle after DONE.
- Changes on X and Y after acceptance have no effect.

Test Plan:
1. X=40C00000 (6.0), Y=40000000 (2.0), start pulse -> done 26 edges later; result=40400000; all flags 0; busy high throughout.
2. X=3F800000, Y=40400000 (1/3) -> result=3EAAAAAA. Exercises the Mx<My path (adj=1) and truncation.
3. Specials, each checking 1-edge latency:
   - BF800000 / 00000000 -> FF800000, inf=1.
   - 00000000 / 00000000 -> 7FC00000, nan=1.
   - 7F800000 / 7F800000 -> 7FC00000, nan=1.
   - 40000000 / 7F800000 -> 00000000, zero=1.
   - 7FC00001 / 3F800000 -> 7FC00000, nan=1.
4. Range limits:
   - 7F000000 / 00800000 -> 7F800000, overflow=1, inf=0.
   - 00800000 / 7F000000 -> 00000000, underflow=1, zero=0.
   - 00400000 (denormal) / 3F800000 -> 00000000, zero=1.
5. Handshake: start at count 10 of DIVIDE with different X and Y -> ignored; the original quotient is delivered. Then start held high -> back-to-back operations, each separated by one IDLE cycle.
6. Reset: reset_n low mid-DIVIDE -> busy, done and flags 0, result 0 immediately (asynchronous). No done pulse. The next start computes correctly.
